// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with lock/button synchronisers, debounce and cause capture
// Optional feature macro: WATCHDOG_EN (RUN-state watchdog, abort cause 3)
module reset_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int STAGE_DELAY     = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LOCK_SETTLE     = 64,
    parameter int WDT_CYCLES      = 1048576
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pll_locked,
    input  logic                  key_n,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic [1:0]            cause
);

    localparam int SEQ_MAX = (LOCK_SETTLE > STAGE_DELAY) ? LOCK_SETTLE : STAGE_DELAY;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(LOCK_SETTLE - 1);
    localparam logic [SEQ_W-1:0] STAGE_LAST  = SEQ_W'(STAGE_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        SETTLE  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t                state;
    logic [SEQ_W-1:0]      seq_cnt;
    logic                  lock_m, lock_s;
    logic                  key_m, key_s;
    logic                  key_db;
    logic [DB_W-1:0]       db_cnt;
    logic                  good;
    logic                  wdt_expired;
    logic [NUM_STAGES-1:0] next_mask;

    assign good      = lock_s & key_db;
    // Thermometer step: release the lowest still-held stage.
    assign next_mask = (rst_n_out << 1) | NUM_STAGES'(1);

    // Two-flop synchronisers; the button idles released (high).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            key_m  <= 1'b1;
            key_s  <= 1'b1;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
            key_m  <= key_n;
            key_s  <= key_m;
        end
    end

    // Debounce: adopt key_s only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_db <= 1'b1;
            db_cnt <= '0;
        end else if (key_s == key_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            key_db <= key_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

`ifdef WATCHDOG_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    // Watchdog counts only while in RUN; any kick or leaving RUN restarts it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wdt_cnt <= '0;
        end else if (state != RUN || wdt_kick) begin
            wdt_cnt <= '0;
        end else if (wdt_cnt != WDT_LAST) begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    assign wdt_expired = (state == RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);
`else
    logic wdt_unused;
    assign wdt_unused  = wdt_kick ^ (WDT_CYCLES == 0);
    assign wdt_expired = 1'b0;
`endif

    // Sequencer: settle, release stages in order, abort all stages at once on a fault.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= HOLD;
            seq_cnt   <= '0;
            rst_n_out <= '0;
            ready     <= 1'b0;
            cause     <= 2'd0;
        end else begin
            case (state)
                HOLD: begin
                    rst_n_out <= '0;
                    ready     <= 1'b0;
                    seq_cnt   <= '0;
                    if (good) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!good) begin
                        state   <= HOLD;
                        seq_cnt <= '0;
                    end else if (seq_cnt == SETTLE_LAST) begin
                        seq_cnt   <= '0;
                        rst_n_out <= NUM_STAGES'(1);
                        if (NUM_STAGES == 1) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        seq_cnt <= seq_cnt + SEQ_W'(1);
                    end
                end
                RELEASE, RUN: begin
                    if (!good || wdt_expired) begin
                        state     <= HOLD;
                        rst_n_out <= '0;
                        ready     <= 1'b0;
                        seq_cnt   <= '0;
                        cause     <= !lock_s ? 2'd1 : (!key_db ? 2'd2 : 2'd3);
                    end else if (state == RELEASE) begin
                        if (seq_cnt == STAGE_LAST) begin
                            seq_cnt   <= '0;
                            rst_n_out <= next_mask;
                            if (&next_mask) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end
                        end else begin
                            seq_cnt <= seq_cnt + SEQ_W'(1);
                        end
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer with a timeline-based reference model
module tb_reset_sequencer;

    localparam int N   = 3;
    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int LS  = 5;
    localparam int WDT = 20;
`ifdef WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic         clock      = 1'b0;
    logic         resetn     = 1'b0;
    logic         pll_locked = 1'b0;
    logic         key_n      = 1'b1;
    logic         wdt_kick   = 1'b0;
    logic [N-1:0] rst_n_out;
    logic         ready;
    logic [1:0]   cause;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int kick_period = 15;
    int last_kick   = 0;

    // Reference model: sequence timeline measured from the edge "good" was first seen.
    bit m_active;
    int m_g;
    int m_ref;
    int m_cause;
    int m_stages;
    bit m_key_db;
    bit lq[$];
    bit kq[$];
    bit khist[$];

    reset_sequencer #(
        .NUM_STAGES      (N),
        .STAGE_DELAY     (SD),
        .DEBOUNCE_CYCLES (DB),
        .LOCK_SETTLE     (LS),
        .WDT_CYCLES      (WDT)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pll_locked (pll_locked),
        .key_n      (key_n),
        .wdt_kick   (wdt_kick),
        .rst_n_out  (rst_n_out),
        .ready      (ready),
        .cause      (cause)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_g      = 0;
        m_ref    = 0;
        m_cause  = 0;
        m_stages = 0;
        m_key_db = 1'b1;
        lq       = '{1'b0, 1'b0};
        kq       = '{1'b1, 1'b1};
        khist.delete();
    endtask

    task automatic model_step();
        bit ls, ks, good, flip;
        int el, st;
        if (!resetn) begin
            model_reset();
            return;
        end
        ls   = lq[0];
        ks   = kq[0];
        good = ls && m_key_db;
        if (!m_active) begin
            if (good) begin
                m_active = 1'b1;
                m_g      = cyc;
            end
        end else begin
            el = cyc - m_g;
            if (!good) begin
                if (el > LS) m_cause = ls ? 2 : 1;
                m_active = 1'b0;
            end else if (WDT_ON && el > LS + (N - 1) * SD) begin
                if (wdt_kick) m_ref = cyc;
                else if (cyc - m_ref >= WDT) begin
                    m_cause  = 3;
                    m_active = 1'b0;
                end
            end
            if (m_active && el == LS + (N - 1) * SD) m_ref = cyc;
        end
        if (m_active) begin
            el = cyc - m_g;
            st = (el < LS) ? 0 : (el - LS) / SD + 1;
            m_stages = (st > N) ? N : st;
        end else begin
            m_stages = 0;
        end
        khist.push_back(ks);
        if (khist.size() > DB) void'(khist.pop_front());
        if (khist.size() == DB) begin
            flip = 1'b1;
            foreach (khist[i]) if (khist[i] == m_key_db) flip = 1'b0;
            if (flip) begin
                m_key_db = !m_key_db;
                khist.delete();
            end
        end
        void'(lq.pop_front());
        lq.push_back(pll_locked);
        void'(kq.pop_front());
        kq.push_back(key_n);
    endtask

    initial model_reset();

    // Compare process: advance model at each edge, check DUT just after it.
    always @(posedge clock) begin
        cyc = cyc + 1;
        model_step();
        #1;
        check("rst_n_out", 32'(rst_n_out), 32'((1 << m_stages) - 1));
        check("ready", 32'(ready), 32'(m_stages == N));
        check("cause", 32'(cause), 32'(m_cause));
    end

    // Background watchdog service.
    always @(negedge clock) begin
        if (kick_period > 0 && (cyc % kick_period) == 0) begin
            wdt_kick  = 1'b1;
            last_kick = cyc + 1;
        end else begin
            wdt_kick = 1'b0;
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 100 && ready !== 1'b1; i++) edges(1);
        check(name, 32'(ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        // Reset state
        edges(2);
        check("reset_rst", 32'(rst_n_out), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_cause", 32'(cause), 32'd0);
        @(negedge clock) resetn = 1'b1;
        edges(3);

        // Power-up: lock first sampled at edge t
        @(negedge clock) pll_locked = 1'b1;
        edges(7);
        check("pwr_t6", 32'(rst_n_out), 32'b000);
        edges(1);
        check("pwr_t7", 32'(rst_n_out), 32'b001);
        edges(3);
        check("pwr_t10", 32'(rst_n_out), 32'b001);
        edges(1);
        check("pwr_t11", 32'(rst_n_out), 32'b011);
        edges(4);
        check("pwr_t15", 32'(rst_n_out), 32'b111);
        check("pwr_ready", 32'(ready), 32'd1);
        check("pwr_cause", 32'(cause), 32'd0);
        edges(10);

        // Lock loss for one cycle
        @(negedge clock) pll_locked = 1'b0;
        @(negedge clock) pll_locked = 1'b1;
        edges(1);
        check("lock_s1", 32'(rst_n_out), 32'b111);
        edges(1);
        check("lock_s2", 32'(rst_n_out), 32'b000);
        check("lock_ready", 32'(ready), 32'd0);
        check("lock_cause", 32'(cause), 32'd1);
        wait_ready("lock_reseq");
        check("lock_cause_hold", 32'(cause), 32'd1);

        // Bounce shorter than the debounce window
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i % 3 == 0) key_n = ~key_n;
        end
        @(negedge clock) key_n = 1'b1;
        edges(5);
        check("bounce_ready", 32'(ready), 32'd1);
        check("bounce_cause", 32'(cause), 32'd1);

        // Held press
        @(negedge clock) key_n = 1'b0;
        edges(10);
        check("press_p9", 32'(ready), 32'd1);
        edges(1);
        check("press_p10", 32'(rst_n_out), 32'b000);
        check("press_cause", 32'(cause), 32'd2);
        edges(30);
        check("press_hold", 32'(rst_n_out), 32'b000);

        // Release, then lock drops on the 3rd SETTLE cycle
        @(negedge clock) key_n = 1'b1;
        edges(11);
        @(negedge clock) pll_locked = 1'b0;
        edges(3);
        check("settle_abort_rst", 32'(rst_n_out), 32'b000);
        check("settle_abort_cause", 32'(cause), 32'd2);
        @(negedge clock) pll_locked = 1'b1;
        edges(2);
        check("settle_v15", 32'(rst_n_out), 32'b000);
        edges(6);
        check("settle_v21", 32'(rst_n_out), 32'b001);
        wait_ready("settle_reseq");
        check("settle_cause", 32'(cause), 32'd2);

        // Simultaneous lock loss and debounced press
        @(negedge clock) key_n = 1'b0;
        edges(7);
        @(negedge clock) pll_locked = 1'b0;
        edges(2);
        check("simul_p9", 32'(ready), 32'd1);
        edges(1);
        check("simul_rst", 32'(rst_n_out), 32'b000);
        check("simul_cause", 32'(cause), 32'd1);
        @(negedge clock) begin
            pll_locked = 1'b1;
            key_n      = 1'b1;
        end
        wait_ready("simul_reseq");

        // Watchdog: serviced every 15 cycles, then starved
        edges(60);
        check("wdt_kicked", 32'(ready), 32'd1);
        kick_period = 0;
        for (int i = 0; i < 60 && cyc < last_kick + 19; i++) edges(1);
        check("wdt_before", 32'(ready), 32'd1);
        edges(1);
`ifdef WATCHDOG_EN
        check("wdt_abort_rst", 32'(rst_n_out), 32'b000);
        check("wdt_abort_cause", 32'(cause), 32'd3);
`else
        check("wdt_off_ready", 32'(ready), 32'd1);
        edges(30);
        check("wdt_off_cause3", 32'(cause == 2'd3), 32'd0);
`endif
        kick_period = 15;
        wait_ready("wdt_reseq");

        // resetn mid-sequence
        @(negedge clock) pll_locked = 1'b0;
        @(negedge clock) pll_locked = 1'b1;
        edges(10);
        check("midrst_pre", 32'(rst_n_out), 32'b001);
        @(negedge clock) resetn = 1'b0;
        #1;
        check("midrst_rst", 32'(rst_n_out), 32'b000);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_cause", 32'(cause), 32'd0);
        edges(2);
        @(negedge clock) resetn = 1'b1;
        wait_ready("midrst_reseq");
        check("midrst_cause_after", 32'(cause), 32'd0);
        edges(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
